// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel pipeline: sequencer states,
// coordinate width and the border padding modes understood by the kernel.
package sobel_pkg;

  localparam int COORD_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } win_state_t;

  // How the kernel fills window taps that fall outside the frame.
  typedef enum logic [1:0] {
    PAD_ZERO      = 2'd0,
    PAD_REPLICATE = 2'd1,
    PAD_MIRROR    = 2'd2
  } pad_mode_t;

endpackage

// File: rtl/pos_counter.sv
// Raster position counter: x wraps at WIDTH-1 and carries into y, which wraps
// at HEIGHT-1. Clear has priority over enable.
module pos_counter
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last_col,
  output logic               last_row
);

  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(HEIGHT - 1);

  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (en) begin
      if (last_col) begin
        x_reg <= '0;
        y_reg <= last_row ? '0 : y_reg + 1'b1;
      end else begin
        x_reg <= x_reg + 1'b1;
      end
    end
  end

  assign x        = x_reg;
  assign y        = y_reg;
  assign last_col = (x_reg == LAST_X);
  assign last_row = (y_reg == LAST_Y);

endmodule

// File: rtl/window_ctrl.sv
// Line buffer sequencer for the 3x3 Sobel window: gates shifts, flushes the
// last rows with zeros and reports the registered window centre and borders.
module window_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               de,
  output logic               lb_shift_en,
  output logic               lb_zero_in,
  output logic               win_valid,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  output logic               at_left,
  output logic               at_right,
  output logic               at_top,
  output logic               at_bottom,
  output logic               frame_done,
  output logic               overrun
);

  localparam int IN_CNT  = 0;
  localparam int CEN_CNT = 1;

  win_state_t state_reg, state_next;
  logic       vsync_reg;
  logic       vsync_rise;
  logic       cnt_clr;
  logic       cnt_en   [2];
  logic [COORD_W-1:0] cnt_x [2];
  logic [COORD_W-1:0] cnt_y [2];
  logic       cnt_last_col [2];
  logic       cnt_last_row [2];
  logic       win_fire, done_fire, ovr_fire;

  logic       win_valid_reg, frame_done_reg, overrun_reg;
  logic [COORD_W-1:0] win_x_reg, win_y_reg;
  logic       at_left_reg, at_right_reg, at_top_reg, at_bottom_reg;

  // hsync carries no information the sequencer needs.
  logic unused_hsync;
  assign unused_hsync = hsync;

  assign vsync_rise = vsync && !vsync_reg;

  // Counter 0 tracks the incoming pixel position, counter 1 the window centre.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      pos_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en[gi]),
        .x        (cnt_x[gi]),
        .y        (cnt_y[gi]),
        .last_col (cnt_last_col[gi]),
        .last_row (cnt_last_row[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      vsync_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      vsync_reg <= vsync;
    end
  end

  always_comb begin
    state_next      = state_reg;
    lb_shift_en     = 1'b0;
    lb_zero_in      = 1'b0;
    cnt_clr         = 1'b0;
    cnt_en[IN_CNT]  = 1'b0;
    cnt_en[CEN_CNT] = 1'b0;
    win_fire        = 1'b0;
    done_fire       = 1'b0;
    ovr_fire        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (vsync_rise) begin
          cnt_clr    = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        lb_shift_en = de;
        if (vsync_rise) begin
          ovr_fire = 1'b1;
          cnt_clr  = 1'b1;
        end else if (de) begin
          cnt_en[IN_CNT] = 1'b1;
          // Shifting input index WIDTH completes WIDTH+1 fill shifts.
          if (cnt_x[IN_CNT] == '0 && cnt_y[IN_CNT] == COORD_W'(1))
            state_next = RUN;
        end
      end
      RUN: begin
        lb_shift_en = de;
        if (vsync_rise) begin
          ovr_fire   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = FILL;
        end else if (de) begin
          cnt_en[IN_CNT]  = 1'b1;
          cnt_en[CEN_CNT] = 1'b1;
          win_fire        = 1'b1;
          if (cnt_last_col[IN_CNT] && cnt_last_row[IN_CNT])
            state_next = FLUSH;
        end
      end
      FLUSH: begin
        lb_shift_en = 1'b1;
        lb_zero_in  = 1'b1;
        if (vsync_rise) begin
          ovr_fire   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = FILL;
        end else begin
          cnt_en[CEN_CNT] = 1'b1;
          win_fire        = 1'b1;
          if (cnt_last_col[CEN_CNT] && cnt_last_row[CEN_CNT]) begin
            done_fire  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Window descriptors appear with the line buffer contents they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      win_x_reg      <= '0;
      win_y_reg      <= '0;
      at_left_reg    <= 1'b0;
      at_right_reg   <= 1'b0;
      at_top_reg     <= 1'b0;
      at_bottom_reg  <= 1'b0;
    end else begin
      win_valid_reg  <= win_fire;
      frame_done_reg <= done_fire;
      overrun_reg    <= ovr_fire;
      if (win_fire) begin
        win_x_reg     <= cnt_x[CEN_CNT];
        win_y_reg     <= cnt_y[CEN_CNT];
        at_left_reg   <= (cnt_x[CEN_CNT] == '0);
        at_right_reg  <= cnt_last_col[CEN_CNT];
        at_top_reg    <= (cnt_y[CEN_CNT] == '0);
        at_bottom_reg <= cnt_last_row[CEN_CNT];
      end
    end
  end

  assign win_valid  = win_valid_reg;
  assign frame_done = frame_done_reg;
  assign overrun    = overrun_reg;
  assign win_x      = win_x_reg;
  assign win_y      = win_y_reg;
  assign at_left    = at_left_reg;
  assign at_right   = at_right_reg;
  assign at_top     = at_top_reg;
  assign at_bottom  = at_bottom_reg;

endmodule

// File: tb/tb_window_ctrl.sv
// Scoreboard bench for window_ctrl on a 4x3 frame: a shift-count model pushes
// expected windows, and registered DUT outputs pop and compare them.
module tb_window_ctrl;

  localparam int W = 4;
  localparam int H = 3;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        l;
    logic        r;
    logic        t;
    logic        b;
    logic        done;
  } win_t;

  logic        clk;
  logic        rst;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        lb_shift_en;
  logic        lb_zero_in;
  logic        win_valid;
  logic [11:0] win_x;
  logic [11:0] win_y;
  logic        at_left, at_right, at_top, at_bottom;
  logic        frame_done;
  logic        overrun;

  int   checks = 0;
  int   errors = 0;
  win_t exp_q[$];

  bit   m_active  = 0;
  bit   m_vs_prev = 0;
  int   m_in      = 0;
  int   m_sh      = 0;

  window_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .lb_shift_en (lb_shift_en),
    .lb_zero_in  (lb_zero_in),
    .win_valid   (win_valid),
    .win_x       (win_x),
    .win_y       (win_y),
    .at_left     (at_left),
    .at_right    (at_right),
    .at_top      (at_top),
    .at_bottom   (at_bottom),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, got, want, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, check combinational
  // outputs mid-cycle and registered outputs just after the edge.
  task automatic step(input logic d, input logic v, input logic r);
    logic exp_sh, exp_z, exp_ovr, exp_win, rise, flushing;
    win_t w, got;
    int   idx;
    de = d; vsync = v; rst = r; hsync = ~d;
    exp_sh = 0; exp_z = 0; exp_ovr = 0; exp_win = 0;
    @(negedge clk);
    if (r) begin
      m_active = 0; m_in = 0; m_sh = 0;
      exp_q.delete();
    end else begin
      rise = v && !m_vs_prev;
      if (!m_active) begin
        if (rise) begin
          m_active = 1; m_in = 0; m_sh = 0;
        end
      end else begin
        flushing = (m_in == W * H);
        exp_sh   = flushing ? 1'b1 : d;
        exp_z    = flushing;
        if (rise) begin
          exp_ovr = 1; m_in = 0; m_sh = 0;
        end else if (exp_sh) begin
          m_sh++;
          if (!flushing) m_in++;
          if (m_sh >= W + 2) begin
            idx    = m_sh - W - 2;
            w.x    = 12'(idx % W);
            w.y    = 12'(idx / W);
            w.l    = (idx % W) == 0;
            w.r    = (idx % W) == W - 1;
            w.t    = (idx / W) == 0;
            w.b    = (idx / W) == H - 1;
            w.done = (idx == W * H - 1);
            exp_q.push_back(w);
            exp_win = 1;
            if (w.done) m_active = 0;
          end
        end
      end
      check_val("lb_shift_en", lb_shift_en, exp_sh);
      check_val("lb_zero_in", lb_zero_in, exp_z);
    end
    m_vs_prev = r ? 1'b0 : v;
    @(posedge clk);
    #1;
    check_val("win_valid", win_valid, exp_win);
    check_val("overrun", overrun, exp_ovr);
    if (r) begin
      check_val("rst_win_x", win_x, 0);
      check_val("rst_win_y", win_y, 0);
      check_val("rst_flags", {at_left, at_right, at_top, at_bottom}, 0);
      check_val("rst_frame_done", frame_done, 0);
    end else if (win_valid) begin
      check_val("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        check_val("win_x", win_x, got.x);
        check_val("win_y", win_y, got.y);
        check_val("at_lrtb", {at_left, at_right, at_top, at_bottom}, {got.l, got.r, got.t, got.b});
        check_val("frame_done", frame_done, got.done);
        $display("window (%0d,%0d) lrtb=%b%b%b%b done=%0b", win_x, win_y,
                 at_left, at_right, at_top, at_bottom, frame_done);
      end
    end else begin
      check_val("frame_done_idle", frame_done, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pixels(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; de = 1'b0; vsync = 1'b0; hsync = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // de before any vsync: no shifts, no windows
    pixels(5, 0);

    // continuous frame
    step(1'b0, 1'b1, 1'b0);
    pixels(W * H, 0);
    idle(8);

    // gapped de
    step(1'b0, 1'b1, 1'b0);
    pixels(W * H, 2);
    idle(8);

    // overrun after 8 pixels, then a full frame
    step(1'b0, 1'b1, 1'b0);
    pixels(8, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    pixels(W * H, 0);
    idle(8);

    // reset mid-RUN, de held high afterwards, then a clean restart
    step(1'b0, 1'b1, 1'b0);
    pixels(8, 0);
    step(1'b1, 1'b0, 1'b1);
    pixels(3, 0);
    step(1'b0, 1'b1, 1'b0);
    pixels(W * H, 0);
    idle(8);

    check_val("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
